reg_file_sb: RTL and testbench

// - Parametrised M x N register file for the pico-MIPS datapath.
// - Has NRD combinational read ports, one write port and a register-0 that always reads 0.
// - Adds a busy-bit scoreboard: issue marks a destination pending, writeback clears it.
// - Decode uses the per-port busy flags to stall on read-after-write hazards.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_scoreboard.sv | 56 +++++
 rtl/reg_file_sb.sv | 79 +++++++
 tb/tb_reg_file_sb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// reg_file_pkg : default sizes and address-width helper for reg_file_sb
// Rev 1.0
// ------------------------------------------------------------------
package reg_file_pkg;

  localparam int REG_M   = 32;
  localparam int REG_N   = 8;
  localparam int REG_NRD = 2;

  function automatic int addr_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ------------------------------------------------------------------
// reg_scoreboard : per-register busy bits, issue sets / writeback clears
// Rev 1.0
// ------------------------------------------------------------------
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int M   = REG_M,
  parameter int NRD = REG_NRD,
  parameter int AW  = addr_w(REG_M)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              any_busy
);

  localparam logic [AW:0] c_m_lim = M[AW:0];

  logic [M-1:0] r_busy;
  logic         w_iss_ok;
  logic         w_clr_ok;

  assign w_iss_ok = iss_en && (iss_addr != '0) && ({1'b0, iss_addr} < c_m_lim);
  assign w_clr_ok = clr_en && (clr_addr != '0) && ({1'b0, clr_addr} < c_m_lim);

  // Issue is applied after clear so a same-cycle issue wins over the older writeback.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_busy <= '0;
    end else begin
      if (w_clr_ok) r_busy[clr_addr] <= 1'b0;
      if (w_iss_ok) r_busy[iss_addr] <= 1'b1;
    end
  end

  assign any_busy = |r_busy;

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_lookup
      logic [AW-1:0] w_addr;
      logic          w_ok;
      assign w_addr     = rd_addr[i*AW +: AW];
      assign w_ok       = (w_addr != '0) && ({1'b0, w_addr} < c_m_lim);
      assign rd_busy[i] = w_ok ? r_busy[w_addr] : 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ------------------------------------------------------------------
// reg_file_sb : M x N register file, NRD read ports, busy scoreboard
// Optional macro REG_FILE_SB_BYPASS_EN enables write-through bypass. Rev 1.0
// ------------------------------------------------------------------
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int M   = REG_M,
  parameter int N   = REG_N,
  parameter int NRD = REG_NRD,
  localparam int AW = addr_w(M)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*N-1:0]  rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              any_busy
);

  localparam logic [AW:0] c_m_lim = M[AW:0];

  logic [N-1:0]   r_mem [M];
  logic           w_wr_ok;
  logic [NRD-1:0] w_sb_busy;

  assign w_wr_ok = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < c_m_lim);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int j = 0; j < M; j++) r_mem[j] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .M   (M),
    .NRD (NRD),
    .AW  (AW)
  ) u_sb (
    .clk      (clk),
    .nreset   (nreset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (w_sb_busy),
    .any_busy (any_busy)
  );

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_ok;
      assign w_addr = rd_addr[i*AW +: AW];
      assign w_ok   = (w_addr != '0) && ({1'b0, w_addr} < c_m_lim);
`ifdef REG_FILE_SB_BYPASS_EN
      // Bypass is gated by nreset so outputs stay zero while reset is held.
      logic w_byp;
      assign w_byp = nreset && w_wr_ok && (wr_addr == w_addr);
      assign rd_data[i*N +: N] = w_byp ? wr_data : (w_ok ? r_mem[w_addr] : '0);
      assign rd_busy[i]        = ~w_byp & w_sb_busy[i];
`else
      assign rd_data[i*N +: N] = w_ok ? r_mem[w_addr] : '0;
      assign rd_busy[i]        = w_sb_busy[i];
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_reg_file_sb : randomized bench for reg_file_sb against an array model
// Rev 1.0
// ------------------------------------------------------------------
module tb_reg_file_sb;

  localparam int M   = 32;
  localparam int N   = 8;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic              clk;
  logic              nreset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*N-1:0]  rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [N-1:0]      wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              any_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] m_mem  [M];
  bit           m_busy [M];

  reg_file_sb #(.M(M), .N(N), .NRD(NRD)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .any_busy (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < M; j++) begin
      m_mem[j]  = '0;
      m_busy[j] = 1'b0;
    end
  endtask

  function automatic logic [N-1:0] exp_data(input int a);
    if (a == 0) return '0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en && int'(wr_addr) == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en && int'(wr_addr) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    for (int j = 0; j < M; j++) if (m_busy[j]) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive at negedge, check combinational reads, then advance the model at posedge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                      input logic ie, input logic [AW-1:0] ia,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    rd_addr = {a1, a0};
    #1;
    chk("rd_data0", rd_data[N-1:0], exp_data(int'(a0)));
    chk("rd_data1", rd_data[2*N-1:N], exp_data(int'(a1)));
    chk("rd_busy0", rd_busy[0], exp_busy(int'(a0)));
    chk("rd_busy1", rd_busy[1], exp_busy(int'(a1)));
    chk("any_busy", any_busy, exp_any());
    @(posedge clk);
    if (we && wa != 0) begin
      m_mem[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (ie && ia != 0) m_busy[ia] = 1'b1;
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    step(1'b0, '0, '0, 1'b0, '0, a0, a1);
  endtask

  initial begin
    model_reset();
    nreset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'hA5;
    iss_en = 1'b1; iss_addr = 5'd5;
    rd_addr = {5'd5, 5'd5};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rd_data, 16'h0);
    chk("rst_busy", rd_busy, 2'b00);
    chk("rst_any", any_busy, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; iss_en = 1'b0;
    nreset = 1'b1;

    for (int k = 0; k < M; k += 2) idle(AW'(k), AW'(k + 1));

    // Zero register ignores writes and issues
    step(1'b1, 5'd0, 8'hFF, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Scoreboard set then clear
    step(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd0);
    idle(5'd3, 5'd3);
    step(1'b1, 5'd3, 8'h3C, 1'b0, '0, 5'd3, 5'd3);
    idle(5'd3, 5'd0);

    // Same-cycle issue and write: data lands, busy stays set
    step(1'b1, 5'd7, 8'h11, 1'b1, 5'd7, 5'd7, 5'd0);
    idle(5'd7, 5'd7);

    // Writeback to a busy register while port 1 reads it
    step(1'b0, '0, '0, 1'b1, 5'd4, 5'd0, 5'd4);
    step(1'b1, 5'd4, 8'h42, 1'b0, '0, 5'd0, 5'd4);
`ifdef REG_FILE_SB_BYPASS_EN
    chk("bypass_data", rd_data[2*N-1:N], 8'h42);
    chk("bypass_busy", rd_busy[1], 1'b0);
`else
    chk("nobypass_data", rd_data[2*N-1:N], 8'h00);
    chk("nobypass_busy", rd_busy[1], 1'b1);
`endif
    idle(5'd4, 5'd4);

    for (int k = 0; k < 400; k++) begin
      logic [AW-1:0] wa, ia, a0, a1;
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      wa = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, M - 1));
      ia = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, M - 1));
      a0 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, M - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), wa, N'($urandom), 1'($urandom_range(0, 1)), ia, a0, a1);
    end

    // Asynchronous reset between edges with live data and busy registers
    step(1'b1, 5'd9, 8'h99, 1'b0, '0, 5'd0, 5'd0);
    step(1'b1, 5'd10, 8'hAA, 1'b1, 5'd9, 5'd9, 5'd0);
    step(1'b0, '0, '0, 1'b1, 5'd10, 5'd9, 5'd10);
    #2;
    rd_addr = {5'd10, 5'd9};
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 8'h55;
    iss_en = 1'b1; iss_addr = 5'd11;
    #1;
    chk("pre_rst_any", any_busy, 1'b1);
    nreset = 1'b0;
    #1;
    chk("async_any", any_busy, 1'b0);
    chk("async_data", rd_data, 16'h0);
    chk("async_busy", rd_busy, 2'b00);
    model_reset();
    @(negedge clk);
    wr_en = 1'b0; iss_en = 1'b0;
    nreset = 1'b1;
    idle(5'd9, 5'd10);
    idle(5'd11, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
